// File: rtl/spu_pkg.sv
// spu_pkg -- shared definitions for the SPU event receiver.
//   spu_state_e   : controller state encoding (IDLE / RUN / ALARM)
//   PRIV_*        : privilege codes carried in the MSBs of e_info
//   NUM_LANES     : number of event lanes / counters
//   priv_allowed(): privilege-mask match; code 00 never matches
package spu_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] PRIV_M = 2'b01;
  localparam logic [1:0] PRIV_S = 2'b10;
  localparam logic [1:0] PRIV_U = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ALARM = 2'b10
  } spu_state_e;

  // mask bit0 = M, bit1 = S, bit2 = U; the invalid code 00 is rejected
  // whatever the mask says.
  function automatic logic priv_allowed(input logic [1:0] priv,
                                        input logic [2:0] mask);
    logic ok;
    ok = 1'b0;
    case (priv)
      PRIV_M:  ok = mask[0];
      PRIV_S:  ok = mask[1];
      PRIV_U:  ok = mask[2];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spu_lane_counter.sv
// spu_lane_counter -- one event lane: wrapping counter, sticky overflow flag
// and threshold-hit detection.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of count and overflow (wins over inc_i)
//   inc_i           count one event this cycle
//   threshold_i     alarm threshold; 0 disables the hit output
//   cnt_o           current count
//   ovf_o           sticky wrap flag
//   hit_o           this cycle's increment lands exactly on threshold_i
module spu_lane_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o,
  output logic                 hit_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 ovf_q, ovf_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      cnt_d = cnt_inc;
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // A wrap lands on 0, which is the "disabled" threshold, so it never hits.
  assign hit_o = inc_i && !clear_i && (threshold_i != '0) && (cnt_inc == threshold_i);
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/spu_event_rx.sv
// spu_event_rx -- filters incoming per-lane event pulses by privilege, source
// ID and (optionally) ASID, counts them per lane and raises an alarm interrupt
// when a lane reaches the programmed threshold.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   evu_e_id_i / e_info_i / s_id_i event pulses per lane, {priv, asid}, source ID
//   cfg_*                         enable, privilege mask, required s_id, ASID
//                                 filter, alarm threshold, clear pulse
//   irq_o / irq_ack_i             alarm interrupt and its acknowledge
//   rd_req_i, rd_lane_i           counter read request (one-cycle latency)
//   rd_valid_o, rd_data_o         read response; data is 0 when not valid
//   overflow_o                    sticky per-lane wrap flags
// Build option: define SPU_RX_ASID_FILTER_EN to enable the ASID filter;
// otherwise cfg_asid_en_i / cfg_asid_i are ignored.
//
// state | meaning
// IDLE  | disabled: no counting, irq_o low
// RUN   | counting, no pending alarm
// ALARM | counting, threshold hit, irq_o high until ack/clear/disable
module spu_event_rx
  import spu_pkg::*;
#(
  parameter int ASID_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_LANES-1:0]  evu_e_id_i,
  input  logic [ASID_WIDTH+1:0] evu_e_info_i,
  input  logic                  evu_s_id_i,
  input  logic                  cfg_enable_i,
  input  logic [2:0]            cfg_priv_mask_i,
  input  logic                  cfg_sid_i,
  input  logic                  cfg_asid_en_i,
  input  logic [ASID_WIDTH-1:0] cfg_asid_i,
  input  logic [CNT_WIDTH-1:0]  cfg_threshold_i,
  input  logic                  cfg_clear_i,
  output logic                  irq_o,
  input  logic                  irq_ack_i,
  input  logic                  rd_req_i,
  input  logic [1:0]            rd_lane_i,
  output logic                  rd_valid_o,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [NUM_LANES-1:0]  overflow_o
);

  // Input stage
  logic [NUM_LANES-1:0]  e_id_q;
  logic [ASID_WIDTH+1:0] e_info_q;
  logic                  s_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e_id_q   <= '0;
      e_info_q <= '0;
      s_id_q   <= 1'b0;
    end else if (cfg_clear_i) begin
      e_id_q   <= '0;
      e_info_q <= '0;
      s_id_q   <= 1'b0;
    end else begin
      e_id_q   <= evu_e_id_i;
      e_info_q <= evu_e_info_i;
      s_id_q   <= evu_s_id_i;
    end
  end

  logic [1:0]            ev_priv;
  logic [ASID_WIDTH-1:0] ev_asid;
  logic                  asid_ok;

  assign ev_priv = e_info_q[ASID_WIDTH+1:ASID_WIDTH];
  assign ev_asid = e_info_q[ASID_WIDTH-1:0];

`ifdef SPU_RX_ASID_FILTER_EN
  assign asid_ok = !cfg_asid_en_i || (ev_asid == cfg_asid_i);
`else
  logic asid_unused;
  assign asid_unused = ^{cfg_asid_en_i, cfg_asid_i, ev_asid};
  assign asid_ok     = 1'b1;
`endif

  spu_state_e state_q, state_d;

  logic event_ok;
  assign event_ok = (state_q != ST_IDLE) && priv_allowed(ev_priv, cfg_priv_mask_i)
                    && (s_id_q == cfg_sid_i) && asid_ok;

  // Lanes
  logic [CNT_WIDTH-1:0] cnt [NUM_LANES];
  logic [NUM_LANES-1:0] ovf;
  logic [NUM_LANES-1:0] hit;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    spu_lane_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (cfg_clear_i),
      .inc_i       (event_ok && e_id_q[i]),
      .threshold_i (cfg_threshold_i),
      .cnt_o       (cnt[i]),
      .ovf_o       (ovf[i]),
      .hit_o       (hit[i])
    );
  end

  assign overflow_o = ovf;

  // Controller; lane hits are already suppressed on a clear cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_enable_i) state_d = ST_IDLE;
        else if (|hit)     state_d = ST_ALARM;
      end
      ST_ALARM: begin
        if (!cfg_enable_i)    state_d = ST_IDLE;
        else if (cfg_clear_i) state_d = ST_RUN;
        else if (|hit)        state_d = ST_ALARM;
        else if (irq_ack_i)   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Decoded straight from the state flop so reset drops it immediately.
  assign irq_o = (state_q == ST_ALARM);

  // Readout returns the value held before this cycle's update.
  logic                 rd_valid_q;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

  assign rd_data_d = rd_req_i ? cnt[rd_lane_i] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: doc/spu_event_rx.md
SPU_EVENT_RX -- requirements
Module: spu_event_rx

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 16, width of the ASID field in e_info.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each lane counter.
REQ-003 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port evu_e_id_i  in  4  per-lane event pulses; bit i is lane i.
REQ-005 SHALL have port evu_e_info_i  in  2+ASID_WIDTH  {priv[1:0], asid}, priv in the MSBs; 01=M, 10=S, 11=U, 00=invalid.
REQ-006 SHALL have port evu_s_id_i  in  1  source/security ID.
REQ-007 SHALL have ports cfg_enable_i in 1 count enable; cfg_priv_mask_i in 3 (bit0 M, bit1 S, bit2 U); cfg_sid_i in 1 required s_id.
REQ-008 SHALL have ports cfg_asid_en_i in 1 and cfg_asid_i in ASID_WIDTH (ASID filter).
REQ-009 SHALL have ports cfg_threshold_i in CNT_WIDTH alarm threshold; cfg_clear_i in 1 single-cycle clear pulse.
REQ-010 SHALL have ports irq_o out 1 alarm interrupt; irq_ack_i in 1 interrupt acknowledge.
REQ-011 SHALL have ports rd_req_i in 1, rd_lane_i in 2, rd_valid_o out 1, rd_data_o out CNT_WIDTH (counter readout).
REQ-012 SHALL have port overflow_o out 4, one sticky wrap flag per lane.

Function
REQ-013 SHALL register e_id/e_info/s_id in one input stage; an event at edge N SHALL appear in the counter at edge N+1 and be visible on reads issued from cycle N+2.
REQ-014 SHALL count lane i only when the registered e_id[i]=1, the priv code's cfg_priv_mask_i bit is set, the registered s_id equals cfg_sid_i, and the ASID filter passes.
REQ-015 SHALL never match priv code 00, regardless of the mask.
REQ-016 SHALL increment all matching lanes in the same cycle.
REQ-017 SHALL wrap a counter from all-ones to 0 and set that lane's overflow_o bit sticky until clear or reset.
REQ-018 SHALL implement the FSM states IDLE, RUN and ALARM.
REQ-019 In IDLE, SHALL not count and SHALL hold irq_o=0.
REQ-020 SHALL transition IDLE->RUN when cfg_enable_i=1, and any state->IDLE when cfg_enable_i=0.
REQ-021 SHALL transition RUN->ALARM when any lane increments to a value equal to cfg_threshold_i; a threshold of 0 SHALL disable alarms.
REQ-022 In ALARM, SHALL hold irq_o=1 and keep counting; irq_ack_i SHALL move to RUN, with irq_o low on the next cycle.
REQ-023 When irq_ack_i coincides with a new threshold hit, SHALL remain in ALARM.
REQ-024 cfg_clear_i SHALL zero all counters, overflow_o and the input stage.
REQ-025 cfg_clear_i SHALL take priority over same-cycle increments.
REQ-026 cfg_clear_i SHALL move ALARM->RUN, or to IDLE if cfg_enable_i=0.
REQ-027 rd_req_i SHALL produce rd_valid_o=1 for exactly one cycle on the next cycle, with rd_data_o = the lane value before that cycle's update; back-to-back requests SHALL be accepted every cycle.
REQ-028 While rd_valid_o=0, rd_data_o SHALL be 0.

Reset
REQ-029 Reset SHALL asynchronously force: FSM=IDLE, counters=0, input stage=0, irq_o=0, overflow_o=0, rd_valid_o=0, rd_data_o=0.
REQ-030 Reset asserted mid-ALARM SHALL drop irq_o immediately, without waiting for a clock edge.

Configuration
REQ-031 With macro SPU_RX_ASID_FILTER_EN defined, the ASID filter SHALL pass only when cfg_asid_en_i=0 or asid==cfg_asid_i.
REQ-032 Without SPU_RX_ASID_FILTER_EN, the ASID filter SHALL always pass, and cfg_asid_en_i/cfg_asid_i SHALL be ignored.

Structure
REQ-033 Package spu_pkg SHALL hold the FSM state enum, the priv encodings (PRIV_M=2'b01, PRIV_S=2'b10, PRIV_U=2'b11) and NUM_LANES=4.
REQ-034 One sub-module spu_lane_counter SHALL be instantiated per lane, implementing the counter, wrap, overflow and threshold-hit logic.

Verification
REQ-035 Enable, mask=3'b111, sid match, e_id=4'b0101 for 3 cycles, priv M -> reading lanes 0 and 2 returns 3, lanes 1 and 3 return 0.
REQ-036 Priv code 00 or mask bit clear (U event, mask=3'b011) -> no counter changes.
REQ-037 threshold=5, 5 lane-1 events -> irq_o=1 the cycle after the 5th count; irq_ack_i -> irq_o=0 next cycle; a coincident ack plus hit -> irq_o stays 1.
REQ-038 Preload a lane to all-ones via events with CNT_WIDTH=4 -> the 16th event gives count 0 and overflow_o[lane]=1; cfg_clear_i -> count 0 and overflow_o 0.
REQ-039 SPU_RX_ASID_FILTER_EN defined, asid_en=1, cfg_asid=0x12, events with asid 0x12 and 0x34 -> only the 0x12 events counted; without the macro both are counted.
REQ-040 Assert rst_ni mid-ALARM -> irq_o=0 asynchronously and all read-back counters=0 after release.
